// File: rtl/node_trace_mailbox.sv
// -----------------------------------------------------------------------------
// node_trace_mailbox
//
// Purpose:
//   This block watches CPU store traffic on the data port. It captures every
//   store to NODE_ADDR into a first-word-fall-through FIFO. It latches the
//   CPU "done" handshake, which is a store of 1 to DONE_ADDR. The host drains
//   the captured node sequence through a valid/ready read port. This is the
//   return path for the computed node list: the host preloads the start and
//   end points, and this block carries the resulting path back out.
//
//   Session states:
//     IDLE -> RUN on the first accepted node store.
//     IDLE or RUN -> DONE on a done store.
//     DONE -> IDLE only on clear.
//   All stores are ignored while the block is in DONE. The FIFO can still be
//   drained in DONE. The `clear` input returns the block to its reset state
//   and takes priority over everything else at that edge.
//
// Parameters:
//   NODE_ADDR  address of the CPU node-point store
//   DONE_ADDR  address of the CPU done-flag store
//   DEPTH      FIFO entries; must be a power of two and at least 2
//   CNT_W      width of the saturating accepted-node counter
//
// Ports:
//   clk         system clock, rising-edge
//   reset       asynchronous active-low reset
//   clear       synchronous session clear
//   MemWrite    CPU store strobe
//   DataAdr     CPU store address
//   WriteData   CPU store data
//   rd_valid    FIFO head valid
//   rd_data     FIFO head data; holds the last popped value while empty
//   rd_ready    host accepts the head
//   fifo_count  occupancy, 0..DEPTH
//   node_total  accepted node stores since reset/clear, saturating
//   done        CPU signalled completion
//   overflow    sticky: at least one node store was dropped on a full FIFO
// -----------------------------------------------------------------------------
module node_trace_mailbox #(
  parameter logic [31:0] NODE_ADDR = 32'h0200_0008,
  parameter logic [31:0] DONE_ADDR = 32'h0200_000C,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         node_total,
  output logic                     done,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  logic [31:0]      mem_q [DEPTH];

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] node_total_q, node_total_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      hold_q, hold_d;

  logic node_store;
  logic done_store;
  logic full;
  logic pop;
  logic push;
  logic mem_we;

  always_comb begin
    // NOTE: every variable gets a default at the top of the block, so no path
    // can leave one unassigned and infer a latch.
    node_store   = MemWrite && (DataAdr == NODE_ADDR) && (state_q != S_DONE);
    done_store   = MemWrite && (DataAdr == DONE_ADDR) && (WriteData == 32'h1)
                   && (state_q != S_DONE);
    full         = (count_q == FULL_CNT);
    pop          = (count_q != '0) && rd_ready;
    // When the FIFO is full, a simultaneous pop frees the head slot, so a
    // write is still possible in that cycle.
    push         = node_store && (!full || pop);
    mem_we       = push && !clear;

    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    node_total_d = node_total_q;
    done_d       = done_q;
    overflow_d   = overflow_q;
    hold_d       = hold_q;

    if (clear) begin
      state_d      = S_IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      node_total_d = '0;
      done_d       = 1'b0;
      overflow_d   = 1'b0;
      hold_d       = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        // Remember the departing head so rd_data can hold it once empty.
        hold_d   = mem_q[rd_ptr_q];
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);

      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      if (node_store && !push) overflow_d = 1'b1;
      // node_total counts accepted stores, including ones that were dropped.
      if (node_store && (node_total_q != '1)) node_total_d = node_total_q + CNT_W'(1);

      if (done_store) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else if (node_store && (state_q == S_IDLE)) begin
        state_d = S_RUN;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      node_total_q <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      node_total_q <= node_total_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      hold_q       <= hold_d;
    end
  end

  // NOTE: the storage array is deliberately not reset. count_q alone decides
  // whether an entry is valid, and rd_data is taken from hold_q while the FIFO
  // is empty, so stale contents can never reach the outputs.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= WriteData;
  end

  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : hold_q;
  assign fifo_count = count_q;
  assign node_total = node_total_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/node_trace_mailbox.md
Name: node_trace_mailbox

Overview:
Bus-side responder for the CPU data port. It snoops CPU store traffic (MemWrite, DataAdr, WriteData) and captures every node-point store into a first-word-fall-through FIFO. It latches the CPU-done handshake and presents the captured node sequence to the host through a valid/ready read port. It is the hardware counterpart of the host preload path: the host writes START/END points in, and this block carries the computed path back out.

Parameters:
NODE_ADDR, 32'h02000008, address of the CPU node-point store
DONE_ADDR, 32'h0200000C, address of the CPU done-flag store
DEPTH, 16, FIFO entries; must be a power of two and at least 2
CNT_W, 16, width of the accepted-node counter

Ports:
clk  input  1  system clock, all state updates on its rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous clear of the capture session
MemWrite  input  1  CPU store strobe
DataAdr  input  32  CPU store address
WriteData  input  32  CPU store data
rd_valid  output  1  FIFO head is valid
rd_data  output  32  FIFO head data
rd_ready  input  1  host accepts the head
fifo_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
node_total  output  CNT_W  accepted node stores since reset or clear, saturating
done  output  1  CPU signalled completion
overflow  output  1  sticky: at least one node store was dropped

Behaviour:
- Reset (reset=0, asynchronous): FIFO emptied, rd_valid=0, rd_data=0, fifo_count=0, node_total=0, done=0, overflow=0, state=IDLE. Reset asserted mid-session aborts it immediately.
- State machine, three states:
  - IDLE to RUN on the first accepted node store.
  - IDLE or RUN to DONE on a done store.
  - DONE to IDLE only on clear.
  - There is no other exit from DONE.
- Node store: MemWrite=1, DataAdr==NODE_ADDR, state!=DONE, sampled on the rising edge of clk.
- Done store: MemWrite=1, DataAdr==DONE_ADDR, WriteData==32'h1. Any other value at DONE_ADDR is ignored.
- Stores of any kind while in DONE are ignored. They affect neither the FIFO, overflow nor node_total.
- Capture latency: 1 cycle. A node store at edge N gives rd_valid=1 and rd_data=WriteData after edge N if the FIFO was empty.
- FWFT read: rd_valid = (fifo_count!=0). rd_data always shows the head entry. A pop occurs at an edge where rd_valid&&rd_ready.
- rd_data holds its last value while empty. It is 0 after reset or clear.
- Push and pop in the same edge:
  - occupancy is unchanged;
  - this is legal even when full;
  - with count=1, the new data becomes the head after the edge.
- Push when full with no pop: data is dropped, overflow is set, and node_total still increments (it counts accepted node stores, not stored entries).
- overflow is sticky until reset or clear.
- node_total saturates at 2^CNT_W-1 and does not wrap.
- Pointer wrap: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_count is tracked separately so the full and empty states are unambiguous.
- done is registered and asserts the cycle after the done-store edge.
- FIFO contents remain readable in DONE, so the host drains after done.
- clear=1 at an edge:
  - returns the block to its reset state;
  - has priority over a simultaneous push, pop or done store in that edge.
- X or Z on WriteData is captured as-is; the block does not filter it.

Test Plan:
- Basic capture: reset, then stores 5, 9, 12 to NODE_ADDR on consecutive cycles with rd_ready=0 -> fifo_count=3, node_total=3, rd_data=5, rd_valid asserted 1 cycle after the first store. Then rd_ready=1 -> pops 5, 9, 12 in order, rd_valid=0 after the 3rd pop.
- Done handshake: store 32'h2 to DONE_ADDR -> done stays 0. Store 32'h1 -> done=1 next cycle. A following store 7 to NODE_ADDR -> fifo_count unchanged, node_total unchanged.
- Full and overflow: 16 node stores 0..15 with no pops -> fifo_count=16. 17th store (99) -> overflow=1, node_total=17, FIFO still drains 0..15.
- Simultaneous push/pop at full: fill with 0..15, then store 20 with rd_ready=1 -> fifo_count stays 16, head becomes 1, and 20 drains last with no overflow.
- Wrap-around: 40 store/pop pairs of values 100..139 at count=1 -> every popped value matches, pointers wrap twice, fifo_count never exceeds 2.
- Clear and reset mid-session: with 3 entries and done=1, pulse clear together with a node store -> fifo_count=0, done=0, overflow=0, node_total=0, store discarded. Reset asserted asynchronously mid-cycle -> all outputs 0 before the next clock edge.
